i2c_eeprom_write_seq: RTL and testbench

Sequencer that sits directly upstream of the single-byte I2C EEPROM writer. It buffers up to `FIFO_DEPTH` data bytes and launches one writer transaction per byte at consecutive register addresses. After each successful byte it waits out the EEPROM internal write cycle, and it retries failed bytes. It turns a "write N bytes starting at address A" request into a single done or fail report for the FMC configuration logic.

---
 rtl/i2c_eeprom_write_seq.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_i2c_eeprom_write_seq.sv | 518 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_eeprom_write_seq.sv
// ---------------------------------------------------------------------------
// i2c_eeprom_write_seq
//
// Purpose: multi-byte write sequencer placed in front of the single-byte I2C
// EEPROM writer. Bytes are buffered in a small FIFO while idle; a start request
// then launches one writer transaction per byte at consecutive register
// addresses. After every writer completion the sequencer idles for WRITE_GAP
// cycles so the EEPROM internal write cycle can finish, and it retries failed
// bytes. The whole sequence ends in a single done or fail pulse.
//
// Optional feature macro: I2C_EEPROM_SEQ_RETRY_EN
//   defined   : a failed byte is retried up to MAX_RETRY extra times.
//   undefined : no retry counter; the first failed byte aborts the sequence.
//
// Ports:
//   clk, nReset          clock, asynchronous active-low reset
//   dev_ext, dev_adr     EEPROM addressing mode / device address (captured)
//   start_adr            first register address (captured)
//   byte_count           bytes to write, 0..FIFO_DEPTH (captured)
//   start                request pulse, honoured only in IDLE
//   wr_data/valid/ready  byte buffer write port (ready only in IDLE, not full)
//   busy                 sequence in progress
//   done / fail          one-cycle completion / abort pulses
//   fail_adr             failing register address, or start_adr on reject
//   bytes_written        bytes written successfully in the last sequence
//   i2c_*                request/response handshake with the byte writer
// ---------------------------------------------------------------------------
module i2c_eeprom_write_seq #(
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_RETRY  = 3,
    parameter int WRITE_GAP  = 625000
) (
    input  logic       clk,
    input  logic       nReset,
    input  logic       dev_ext,
    input  logic [6:0] dev_adr,
    input  logic [7:0] start_adr,
    input  logic [4:0] byte_count,
    input  logic       start,
    input  logic [7:0] wr_data,
    input  logic       wr_valid,
    output logic       wr_ready,
    output logic       busy,
    output logic       done,
    output logic       fail,
    output logic [7:0] fail_adr,
    output logic [4:0] bytes_written,
    output logic       i2c_dev_ext,
    output logic [6:0] i2c_dev_adr,
    output logic [7:0] i2c_reg_adr,
    output logic [7:0] i2c_reg_dat,
    output logic       i2c_start_write,
    input  logic       i2c_wr_done,
    input  logic       i2c_error
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int GW = (WRITE_GAP > 0) ? $clog2(WRITE_GAP + 1) : 1;

    localparam logic [5:0]    DEPTH_C   = 6'(FIFO_DEPTH);
    localparam logic [4:0]    DEPTH_LVL = 5'(FIFO_DEPTH);
    localparam logic [AW-1:0] LAST_PTR  = AW'(FIFO_DEPTH - 1);
    localparam logic [GW-1:0] GAP_C     = GW'(WRITE_GAP);

`ifdef I2C_EEPROM_SEQ_RETRY_EN
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0] MAX_RETRY_C = RW'(MAX_RETRY);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_LAUNCH,
        S_WAIT,
        S_GAP,
        S_FINISH,
        S_ABORT,
        S_REJECT
    } state_t;

    state_t         state_q,     state_d;
    logic           busy_q,      busy_d;
    logic           dev_ext_q,   dev_ext_d;
    logic [6:0]     dev_adr_q,   dev_adr_d;
    logic [7:0]     start_adr_q, start_adr_d;
    logic [4:0]     count_q,     count_d;
    logic [4:0]     bw_q,        bw_d;
    logic [7:0]     fail_adr_q,  fail_adr_d;
    logic [7:0]     reg_adr_q,   reg_adr_d;
    logic [7:0]     reg_dat_q,   reg_dat_d;
    logic           start_wr_q,  start_wr_d;
    logic           err_q,       err_d;
    logic [GW-1:0]  gap_q,       gap_d;
    logic [AW-1:0]  rptr_q,      rptr_d;
    logic [AW-1:0]  wptr_q,      wptr_d;
    logic [4:0]     level_q,     level_d;
`ifdef I2C_EEPROM_SEQ_RETRY_EN
    logic [RW-1:0]  retry_q,     retry_d;
`endif

    logic [7:0]     mem_q [FIFO_DEPTH];
    logic           push;
    logic           pop;
    logic           flush;
    logic           ready_int;
    logic [7:0]     cur_adr;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + AW'(1);
    endfunction

    // Register address of the byte in flight; 8-bit wrap is intended.
    assign cur_adr   = start_adr_q + {3'b000, bw_q};
    assign ready_int = (state_q == S_IDLE) && (level_q != DEPTH_LVL);
    assign push      = wr_valid & ready_int;

    assign wr_ready        = ready_int;
    assign busy            = busy_q;
    assign done            = (state_q == S_FINISH);
    assign fail            = (state_q == S_ABORT) || (state_q == S_REJECT);
    assign fail_adr        = fail_adr_q;
    assign bytes_written   = bw_q;
    assign i2c_dev_ext     = dev_ext_q;
    assign i2c_dev_adr     = dev_adr_q;
    assign i2c_reg_adr     = reg_adr_q;
    assign i2c_reg_dat     = reg_dat_q;
    assign i2c_start_write = start_wr_q;

    // Next-state and control decode.
    always_comb begin
        state_d     = state_q;
        dev_ext_d   = dev_ext_q;
        dev_adr_d   = dev_adr_q;
        start_adr_d = start_adr_q;
        count_d     = count_q;
        bw_d        = bw_q;
        fail_adr_d  = fail_adr_q;
        reg_adr_d   = reg_adr_q;
        reg_dat_d   = reg_dat_q;
        start_wr_d  = start_wr_q;
        err_d       = err_q;
        gap_d       = gap_q;
        pop         = 1'b0;
        flush       = 1'b0;
`ifdef I2C_EEPROM_SEQ_RETRY_EN
        retry_d     = retry_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dev_ext_d   = dev_ext;
                    dev_adr_d   = dev_adr;
                    start_adr_d = start_adr;
                    count_d     = byte_count;
                    bw_d        = '0;
`ifdef I2C_EEPROM_SEQ_RETRY_EN
                    retry_d     = '0;
`endif
                    state_d     = S_CHECK;
                end
            end
            S_CHECK: begin
                if (count_q == 5'd0) begin
                    state_d = S_FINISH;
                end else if (({1'b0, count_q} > DEPTH_C) || (count_q > level_q)) begin
                    // fail_adr is loaded on entry so it is valid with the fail pulse.
                    fail_adr_d = start_adr_q;
                    state_d    = S_REJECT;
                end else begin
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                reg_dat_d  = mem_q[rptr_q];
                reg_adr_d  = cur_adr;
                start_wr_d = 1'b1;
                err_d      = 1'b0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                // Error sampled in the same cycle as completion still counts.
                err_d = err_q | i2c_error;
                if (i2c_wr_done) begin
                    start_wr_d = 1'b0;
                    gap_d      = GAP_C;
                    state_d    = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - GW'(1);
                end else if (!err_q) begin
                    pop  = 1'b1;
                    bw_d = bw_q + 5'd1;
`ifdef I2C_EEPROM_SEQ_RETRY_EN
                    retry_d = '0;
`endif
                    state_d = ((bw_q + 5'd1) == count_q) ? S_FINISH : S_LAUNCH;
                end else begin
`ifdef I2C_EEPROM_SEQ_RETRY_EN
                    if (retry_q < MAX_RETRY_C) begin
                        retry_d = retry_q + RW'(1);
                        state_d = S_LAUNCH;
                    end else begin
                        fail_adr_d = cur_adr;
                        state_d    = S_ABORT;
                    end
`else
                    fail_adr_d = cur_adr;
                    state_d    = S_ABORT;
`endif
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            S_ABORT: begin
                flush   = 1'b1;
                state_d = S_IDLE;
            end
            S_REJECT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // FIFO pointer/level bookkeeping; push (IDLE) and pop (GAP) never coincide.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (flush) begin
            rptr_d  = wptr_q;
            level_d = '0;
        end else begin
            if (push) begin
                wptr_d  = ptr_inc(wptr_q);
                level_d = level_q + 5'd1;
            end
            if (pop) begin
                rptr_d  = ptr_inc(rptr_q);
                level_d = level_q - 5'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            dev_ext_q   <= 1'b0;
            dev_adr_q   <= '0;
            start_adr_q <= '0;
            count_q     <= '0;
            bw_q        <= '0;
            fail_adr_q  <= '0;
            reg_adr_q   <= '0;
            reg_dat_q   <= '0;
            start_wr_q  <= 1'b0;
            err_q       <= 1'b0;
            gap_q       <= '0;
            rptr_q      <= '0;
            wptr_q      <= '0;
            level_q     <= '0;
`ifdef I2C_EEPROM_SEQ_RETRY_EN
            retry_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            dev_ext_q   <= dev_ext_d;
            dev_adr_q   <= dev_adr_d;
            start_adr_q <= start_adr_d;
            count_q     <= count_d;
            bw_q        <= bw_d;
            fail_adr_q  <= fail_adr_d;
            reg_adr_q   <= reg_adr_d;
            reg_dat_q   <= reg_dat_d;
            start_wr_q  <= start_wr_d;
            err_q       <= err_d;
            gap_q       <= gap_d;
            rptr_q      <= rptr_d;
            wptr_q      <= wptr_d;
            level_q     <= level_d;
`ifdef I2C_EEPROM_SEQ_RETRY_EN
            retry_q     <= retry_d;
`endif
        end
    end

    // Storage needs no reset: the level register alone defines valid contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= wr_data;
        end
    end

endmodule

// File: tb/tb_i2c_eeprom_write_seq.sv
// ---------------------------------------------------------------------------
// tb_i2c_eeprom_write_seq
//
// Bench for i2c_eeprom_write_seq with WRITE_GAP=8 and a behavioural byte
// writer that completes 20 cycles after each launch. Expected writer
// transactions are queued when a sequence is set up and popped as the writer
// model observes launches. Expectations follow I2C_EEPROM_SEQ_RETRY_EN.
// ---------------------------------------------------------------------------
module tb_i2c_eeprom_write_seq;

    typedef struct packed {
        logic [7:0] adr;
        logic [7:0] dat;
    } xfer_t;

    logic       clk = 1'b0;
    logic       nReset;
    logic       dev_ext;
    logic [6:0] dev_adr;
    logic [7:0] start_adr;
    logic [4:0] byte_count;
    logic       start;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;
    logic       busy;
    logic       done;
    logic       fail;
    logic [7:0] fail_adr;
    logic [4:0] bytes_written;
    logic       i2c_dev_ext;
    logic [6:0] i2c_dev_adr;
    logic [7:0] i2c_reg_adr;
    logic [7:0] i2c_reg_dat;
    logic       i2c_start_write;
    logic       i2c_wr_done;
    logic       i2c_error;

    int    vectors     = 0;
    int    miscompares = 0;
    int    launches    = 0;
    int    done_cnt    = 0;
    int    fail_cnt    = 0;
    int    err_left    = 0;   // <0: error on every attempt
    logic [7:0] err_adr = 8'h00;
    xfer_t exp_q[$];

    always #5 clk = ~clk;

    i2c_eeprom_write_seq #(
        .FIFO_DEPTH(16),
        .MAX_RETRY (3),
        .WRITE_GAP (8)
    ) dut (
        .clk            (clk),
        .nReset         (nReset),
        .dev_ext        (dev_ext),
        .dev_adr        (dev_adr),
        .start_adr      (start_adr),
        .byte_count     (byte_count),
        .start          (start),
        .wr_data        (wr_data),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .busy           (busy),
        .done           (done),
        .fail           (fail),
        .fail_adr       (fail_adr),
        .bytes_written  (bytes_written),
        .i2c_dev_ext    (i2c_dev_ext),
        .i2c_dev_adr    (i2c_dev_adr),
        .i2c_reg_adr    (i2c_reg_adr),
        .i2c_reg_dat    (i2c_reg_dat),
        .i2c_start_write(i2c_start_write),
        .i2c_wr_done    (i2c_wr_done),
        .i2c_error      (i2c_error)
    );

    // Behavioural byte writer: completion 20 cycles after launch, optional
    // error pulse in the preceding cycle.
    initial begin : writer_model
        int    wst;
        int    wcnt;
        bit    do_err;
        xfer_t cur;
        xfer_t want;
        wst = 0; wcnt = 0; do_err = 0; cur = '0;
        i2c_error = 1'b0;
        i2c_wr_done = 1'b0;
        forever begin
            @(posedge clk); #2;
            i2c_error = 1'b0;
            i2c_wr_done = 1'b0;
            if (!nReset) begin
                wst = 0;
            end else if (wst == 0) begin
                if (i2c_start_write === 1'b1) begin
                    launches++;
                    cur.adr = i2c_reg_adr;
                    cur.dat = i2c_reg_dat;
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL launch_unexpected: got adr=%02h dat=%02h, required no launch",
                                 cur.adr, cur.dat);
                    end else begin
                        want = exp_q.pop_front();
                        if (cur !== want) begin
                            miscompares++;
                            $display("FAIL launch_adr_dat: got %02h/%02h, required %02h/%02h",
                                     cur.adr, cur.dat, want.adr, want.dat);
                        end
                    end
                    vectors++;
                    if (i2c_dev_adr !== 7'h50 || i2c_dev_ext !== 1'b1) begin
                        miscompares++;
                        $display("FAIL launch_dev: got %02h/%0b, required 50/1", i2c_dev_adr, i2c_dev_ext);
                    end
                    do_err = (cur.adr == err_adr) && (err_left != 0);
                    if (do_err && err_left > 0) err_left--;
                    wcnt = 0;
                    wst = 1;
                end
            end else if (wst == 1) begin
                wcnt++;
                if (wcnt == 19 && do_err) i2c_error = 1'b1;
                if (wcnt == 20) begin
                    vectors++;
                    if (i2c_reg_adr !== cur.adr || i2c_reg_dat !== cur.dat || i2c_start_write !== 1'b1) begin
                        miscompares++;
                        $display("FAIL hold_stable: got %02h/%02h sw=%0b, required %02h/%02h sw=1",
                                 i2c_reg_adr, i2c_reg_dat, i2c_start_write, cur.adr, cur.dat);
                    end
                    i2c_wr_done = 1'b1;
                    wst = 2;
                end
            end else begin
                if (i2c_start_write === 1'b0) wst = 0;
            end
        end
    end

    // Pulse monitor: done/fail last one cycle and never coincide.
    initial begin : pulse_monitor
        logic done_prev;
        logic fail_prev;
        done_prev = 1'b0;
        fail_prev = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                done_cnt++;
                vectors++;
                if (done_prev !== 1'b0 || fail !== 1'b0) begin
                    miscompares++;
                    $display("FAIL done_pulse: prev=%0b fail=%0b, required 0/0", done_prev, fail);
                end
            end
            if (fail === 1'b1) begin
                fail_cnt++;
                vectors++;
                if (fail_prev !== 1'b0) begin
                    miscompares++;
                    $display("FAIL fail_pulse: prev=%0b, required 0", fail_prev);
                end
            end
            done_prev = done;
            fail_prev = fail;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        nReset = 1'b0;
        @(posedge clk); #1;
        nReset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic push_byte(input logic [7:0] d);
        wr_data  = d;
        wr_valid = 1'b1;
        @(posedge clk); #1;
        wr_valid = 1'b0;
    endtask

    task automatic start_seq(input logic [7:0] adr, input logic [4:0] cnt);
        start_adr  = adr;
        byte_count = cnt;
        start      = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
    endtask

    task automatic wait_end(input int bound, output bit d, output bit f, output bit to);
        d = 0; f = 0; to = 1;
        for (int i = 0; i < bound; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || fail === 1'b1) begin
                d = done; f = fail; to = 0;
                return;
            end
        end
    endtask

    // Fills the FIFO to count the free space, then resets to empty it again.
    task automatic measure_level(output int lvl);
        int cnt;
        cnt = 0;
        wr_data = 8'h5A;
        for (int i = 0; i < 20; i++) begin
            if (wr_ready !== 1'b1) break;
            wr_valid = 1'b1;
            @(posedge clk); #1;
            cnt++;
        end
        wr_valid = 1'b0;
        lvl = 16 - cnt;
        do_reset();
    endtask

    task automatic test_reset();
        nReset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({wr_ready, busy, done, fail, i2c_start_write} !== 5'b10000) begin
            miscompares++;
            $display("FAIL reset_ctrl: got rdy/busy/done/fail/sw=%05b, required 10000",
                     {wr_ready, busy, done, fail, i2c_start_write});
        end
        vectors++;
        if ({fail_adr, bytes_written, i2c_reg_adr, i2c_reg_dat, i2c_dev_adr, i2c_dev_ext} !== '0) begin
            miscompares++;
            $display("FAIL reset_data: got fa=%02h bw=%0d adr=%02h dat=%02h dev=%02h ext=%0b, required all 0",
                     fail_adr, bytes_written, i2c_reg_adr, i2c_reg_dat, i2c_dev_adr, i2c_dev_ext);
        end
        nReset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        bit d, f, to;
        int l0, lvl;
        l0 = launches;
        push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
        exp_q.push_back('{8'h10, 8'h11});
        exp_q.push_back('{8'h11, 8'h22});
        exp_q.push_back('{8'h12, 8'h33});
        start_seq(8'h10, 5'd3);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_busy: got %0b, required 1", busy);
        end
        wait_end(1000, d, f, to);
        vectors++;
        if ({to, d, f} !== 3'b010) begin
            miscompares++;
            $display("FAIL basic_end: got timeout/done/fail=%03b, required 010", {to, d, f});
        end
        vectors++;
        if (bytes_written !== 5'd3 || launches - l0 != 3 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL basic_count: got bw=%0d launches=%0d left=%0d, required 3/3/0",
                     bytes_written, launches - l0, exp_q.size());
        end
        @(posedge clk); #1;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_after: got busy=%0b done=%0b, required 0/0", busy, done);
        end
        measure_level(lvl);
        vectors++;
        if (lvl != 0) begin
            miscompares++;
            $display("FAIL basic_fifo_empty: got level %0d, required 0", lvl);
        end
    endtask

    task automatic test_wrap();
        bit d, f, to;
        push_byte(8'hA0); push_byte(8'hA1); push_byte(8'hA2);
        exp_q.push_back('{8'hFE, 8'hA0});
        exp_q.push_back('{8'hFF, 8'hA1});
        exp_q.push_back('{8'h00, 8'hA2});
        start_seq(8'hFE, 5'd3);
        wait_end(1000, d, f, to);
        vectors++;
        if ({to, d, f} !== 3'b010 || bytes_written !== 5'd3 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL wrap_end: got t/d/f=%03b bw=%0d left=%0d, required 010/3/0",
                     {to, d, f}, bytes_written, exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_retry();
        bit d, f, to;
        int l0, lvl;
        l0 = launches;
        err_adr = 8'h05; err_left = 2;
        push_byte(8'hB0); push_byte(8'hB1); push_byte(8'hB2);
        exp_q.push_back('{8'h04, 8'hB0});
        exp_q.push_back('{8'h05, 8'hB1});
`ifdef I2C_EEPROM_SEQ_RETRY_EN
        exp_q.push_back('{8'h05, 8'hB1});
        exp_q.push_back('{8'h05, 8'hB1});
        exp_q.push_back('{8'h06, 8'hB2});
`endif
        start_seq(8'h04, 5'd3);
        wait_end(2000, d, f, to);
`ifdef I2C_EEPROM_SEQ_RETRY_EN
        vectors++;
        if ({to, d, f} !== 3'b010 || bytes_written !== 5'd3 || launches - l0 != 5) begin
            miscompares++;
            $display("FAIL retry_end: got t/d/f=%03b bw=%0d launches=%0d, required 010/3/5",
                     {to, d, f}, bytes_written, launches - l0);
        end
        @(posedge clk); #1;
`else
        vectors++;
        if ({to, d, f} !== 3'b001 || fail_adr !== 8'h05 || bytes_written !== 5'd1 || launches - l0 != 2) begin
            miscompares++;
            $display("FAIL retry_end: got t/d/f=%03b fa=%02h bw=%0d launches=%0d, required 001/05/1/2",
                     {to, d, f}, fail_adr, bytes_written, launches - l0);
        end
        @(posedge clk); #1;
        measure_level(lvl);
        vectors++;
        if (lvl != 0) begin
            miscompares++;
            $display("FAIL retry_flush: got level %0d, required 0", lvl);
        end
`endif
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL retry_left: got %0d queued, required 0", exp_q.size());
        end
        err_left = 0;
    endtask

    task automatic test_abort();
        bit d, f, to;
        int l0, lvl;
        l0 = launches;
        err_adr = 8'h05; err_left = -1;
        push_byte(8'hC0); push_byte(8'hC1); push_byte(8'hC2);
        exp_q.push_back('{8'h04, 8'hC0});
        exp_q.push_back('{8'h05, 8'hC1});
`ifdef I2C_EEPROM_SEQ_RETRY_EN
        exp_q.push_back('{8'h05, 8'hC1});
        exp_q.push_back('{8'h05, 8'hC1});
        exp_q.push_back('{8'h05, 8'hC1});
`endif
        start_seq(8'h04, 5'd3);
        wait_end(2000, d, f, to);
        vectors++;
        if ({to, d, f} !== 3'b001 || fail_adr !== 8'h05 || bytes_written !== 5'd1) begin
            miscompares++;
            $display("FAIL abort_end: got t/d/f=%03b fa=%02h bw=%0d, required 001/05/1",
                     {to, d, f}, fail_adr, bytes_written);
        end
        vectors++;
        if (exp_q.size() != 0 || launches - l0 != 1 + (dut_retry_en() ? 4 : 1)) begin
            miscompares++;
            $display("FAIL abort_launches: got %0d (left %0d), required %0d",
                     launches - l0, exp_q.size(), 1 + (dut_retry_en() ? 4 : 1));
        end
        err_left = 0;
        @(posedge clk); #1;
        measure_level(lvl);
        vectors++;
        if (lvl != 0) begin
            miscompares++;
            $display("FAIL abort_flush: got level %0d, required 0", lvl);
        end
    endtask

    function automatic bit dut_retry_en();
`ifdef I2C_EEPROM_SEQ_RETRY_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic test_reject();
        bit d, f, to;
        int l0, lvl;
        l0 = launches;
        push_byte(8'hD0); push_byte(8'hD1);
        start_seq(8'h30, 5'd3);
        wait_end(50, d, f, to);
        vectors++;
        if ({to, d, f} !== 3'b001 || fail_adr !== 8'h30 || launches != l0) begin
            miscompares++;
            $display("FAIL reject_short: got t/d/f=%03b fa=%02h launches=%0d, required 001/30/0",
                     {to, d, f}, fail_adr, launches - l0);
        end
        @(posedge clk); #1;
        measure_level(lvl);
        vectors++;
        if (lvl != 2) begin
            miscompares++;
            $display("FAIL reject_level: got level %0d, required 2", lvl);
        end
        start_seq(8'h40, 5'd17);
        wait_end(50, d, f, to);
        vectors++;
        if ({to, d, f} !== 3'b001 || fail_adr !== 8'h40) begin
            miscompares++;
            $display("FAIL reject_over: got t/d/f=%03b fa=%02h, required 001/40", {to, d, f}, fail_adr);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_zero();
        int l0;
        l0 = launches;
        start_seq(8'h60, 5'd0);
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_early: got done=%0b one cycle after start, required 0", done);
        end
        @(posedge clk); #1;
        vectors++;
        if (done !== 1'b1 || fail !== 1'b0 || bytes_written !== 5'd0) begin
            miscompares++;
            $display("FAIL zero_done: got done=%0b fail=%0b bw=%0d, required 1/0/0", done, fail, bytes_written);
        end
        @(posedge clk); #1;
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0 || launches != l0) begin
            miscompares++;
            $display("FAIL zero_after: got done=%0b busy=%0b launches=%0d, required 0/0/0",
                     done, busy, launches - l0);
        end
    endtask

    task automatic test_reset_mid();
        int d0, f0, l0, lvl;
        bit seen;
        push_byte(8'hE0); push_byte(8'hE1);
        exp_q.push_back('{8'h50, 8'hE0});
        start_seq(8'h50, 5'd2);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (i2c_start_write === 1'b1) begin
                seen = 1;
                break;
            end
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL midrst_launch: got no i2c_start_write within 20 cycles, required launch");
        end
        repeat (5) @(posedge clk);
        #1;
        nReset = 1'b0;
        #1;
        vectors++;
        if ({i2c_start_write, busy, wr_ready, done, fail} !== 5'b00100) begin
            miscompares++;
            $display("FAIL midrst_outputs: got sw/busy/rdy/done/fail=%05b, required 00100",
                     {i2c_start_write, busy, wr_ready, done, fail});
        end
        @(posedge clk); #1;
        nReset = 1'b1;
        d0 = done_cnt; f0 = fail_cnt; l0 = launches;
        repeat (80) @(posedge clk);
        #1;
        vectors++;
        if (done_cnt != d0 || fail_cnt != f0 || launches != l0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL midrst_quiet: got done+%0d fail+%0d launches+%0d left=%0d, required all 0",
                     done_cnt - d0, fail_cnt - f0, launches - l0, exp_q.size());
        end
        measure_level(lvl);
        vectors++;
        if (lvl != 0) begin
            miscompares++;
            $display("FAIL midrst_fifo: got level %0d, required 0", lvl);
        end
    endtask

    initial begin : main
        nReset     = 1'b0;
        dev_ext    = 1'b1;
        dev_adr    = 7'h50;
        start_adr  = 8'h00;
        byte_count = 5'd0;
        start      = 1'b0;
        wr_data    = 8'h00;
        wr_valid   = 1'b0;
        test_reset();
        test_basic();
        test_wrap();
        test_retry();
        test_abort();
        test_reject();
        test_zero();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
